// File: rtl/control_sequencer_if.sv
// control_sequencer_if: strobe bundle between the hardwired
// control sequencer and the 32-bit datapath.
interface control_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_rdy;
  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        PCin;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Zin;
  logic        Zlowout;
  logic        Zhighout;
  logic        HIin;
  logic        LOin;
  logic [15:0] reg_in;
  logic [15:0] reg_out;
  logic [3:0]  ALU_select;
  logic        instr_done;
  logic        halted;
  logic [1:0]  fault;

  modport master (
    input  run, ir, mem_rdy,
    output PCout, MARin, IncPC, PCin,
    output Read, MDRin, MDRout,
    output IRin, Yin, Zin,
    output Zlowout, Zhighout,
    output HIin, LOin,
    output reg_in, reg_out, ALU_select,
    output instr_done, halted, fault
  );

  modport slave (
    output run, ir, mem_rdy,
    input  PCout, MARin, IncPC, PCin,
    input  Read, MDRin, MDRout,
    input  IRin, Yin, Zin,
    input  Zlowout, Zhighout,
    input  HIin, LOin,
    input  reg_in, reg_out, ALU_select,
    input  instr_done, halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch / reg-reg execute sequencer.
// Strobes decode from the state register; T3+ also read the IR.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] fault_q, fault_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md, is_nop, is_hlt;
  logic       unused_ir;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  assign is_alu = (op <= 5'd13);
  assign is_md  = (op == 5'd14) || (op == 5'd15);
  assign is_nop = (op == 5'd26);
  assign is_hlt = (op == 5'd31);

  // state, wait counter and sticky fault registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // next state, memory wait counting and fault capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (bus.mem_rdy) begin
          state_d = S_T2;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(MEM_TIMEOUT)) begin
            state_d = S_HALT;
            fault_d = 2'b10;
          end
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        unique case (1'b1)
          is_alu, is_md: state_d = S_T4;
          is_nop: state_d = bus.run ? S_T0 : S_IDLE;
          is_hlt: state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_md) state_d = S_T6;
        else state_d = bus.run ? S_T0 : S_IDLE;
      end
      S_T6:   state_d = bus.run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // per-step strobes; everything idles low by default
  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.PCin       = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Zin        = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.reg_in     = 16'd0;
    bus.reg_out    = 16'd0;
    bus.ALU_select = 4'd0;
    bus.instr_done = 1'b0;
    bus.halted     = 1'b0;
    bus.fault      = fault_q;
    unique case (state_q)
      S_IDLE: ;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_md) begin
          bus.reg_out = 16'd1 << rb;
          bus.Yin     = 1'b1;
        end
        if (is_nop) bus.instr_done = 1'b1;
      end
      S_T4: begin
        bus.reg_out    = 16'd1 << rc;
        bus.Zin        = 1'b1;
        bus.ALU_select = op[3:0];
      end
      S_T5: begin
        bus.Zlowout    = 1'b1;
        bus.ALU_select = op[3:0];
        if (is_md) begin
          bus.LOin = 1'b1;
        end else begin
          bus.reg_in     = 16'd1 << ra;
          bus.instr_done = 1'b1;
        end
      end
      S_T6: begin
        bus.Zhighout   = 1'b1;
        bus.HIin       = 1'b1;
        bus.instr_done = 1'b1;
        bus.ALU_select = op[3:0];
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
